// File: rtl/datapath_sequencer.sv
// datapath_sequencer: accepts (num, key) requests, holds the operands for the
// 4-bit encrypt datapath, strobes its enables through the two-register
// pipeline and tracks per-entry occupancy and overwrite status.
module datapath_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_num,
    input  logic [3:0]  in_key,
    input  logic        clear,
    output logic        in_ready,
    output logic [3:0]  num,
    output logic [3:0]  key,
    output logic        en,
    output logic        we,
    output logic        done,
    output logic [15:0] wr_mask,
    output logic [7:0]  wr_count,
    output logic        overwrite
);

    localparam int unsigned OP_W    = 4;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROT   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q;
    logic [OP_W-1:0]      num_q;
    logic [OP_W-1:0]      key_q;
    logic                 en_q;
    logic                 we_q;
    logic                 done_q;
    logic [ENTRIES-1:0]   wr_mask_q;
    logic [CNT_W-1:0]     wr_count_q;
    logic                 overwrite_q;

    // Sequencer: strobes are registered alongside the state they decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            key_q       <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            wr_mask_q   <= '0;
            wr_count_q  <= '0;
            overwrite_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Clear first so a same-edge accept only sets its own bit later.
                    if (clear) begin
                        wr_mask_q   <= '0;
                        overwrite_q <= 1'b0;
                    end
                    if (in_valid) begin
                        num_q   <= in_num;
                        key_q   <= in_key;
                        en_q    <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= S_ROT;
                end
                S_ROT: begin
                    en_q    <= 1'b0;
                    we_q    <= 1'b1;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    we_q              <= 1'b0;
                    done_q            <= 1'b1;
                    wr_mask_q[num_q]  <= 1'b1;
                    wr_count_q        <= wr_count_q + CNT_W'(1);
                    if (wr_mask_q[num_q]) begin
                        overwrite_q <= 1'b1;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    en_q    <= 1'b0;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is a plain decode of the registered state.
    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    assign num       = num_q;
    assign key       = key_q;
    assign en        = en_q;
    assign we        = we_q;
    assign done      = done_q;
    assign wr_mask   = wr_mask_q;
    assign wr_count  = wr_count_q;
    assign overwrite = overwrite_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed scenarios plus a randomized run,
// each cycle compared against a transaction-level model of the status.
module tb_datapath_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_num;
    logic [3:0]  in_key;
    logic        clear;
    logic        in_ready;
    logic [3:0]  num;
    logic [3:0]  key;
    logic        en;
    logic        we;
    logic        done;
    logic [15:0] wr_mask;
    logic [7:0]  wr_count;
    logic        overwrite;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the status outputs should read.
    logic [15:0] exp_mask;
    int          exp_count;
    logic        exp_ovw;

    datapath_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_num    (in_num),
        .in_key    (in_key),
        .clear     (clear),
        .in_ready  (in_ready),
        .num       (num),
        .key       (key),
        .en        (en),
        .we        (we),
        .done      (done),
        .wr_mask   (wr_mask),
        .wr_count  (wr_count),
        .overwrite (overwrite)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".wr_mask"},   32'(wr_mask),   32'(exp_mask));
        check({tag, ".wr_count"},  32'(wr_count),  32'(exp_count % 256));
        check({tag, ".overwrite"}, 32'(overwrite), 32'(exp_ovw));
    endtask

    task automatic model_reset();
        exp_mask  = '0;
        exp_count = 0;
        exp_ovw   = 1'b0;
    endtask

    // One request from accept to the following IDLE cycle, checked every cycle.
    task automatic run_req(input logic [3:0] n, input logic [3:0] k,
                           input logic clr, input logic busy_clr,
                           input logic keep_valid);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_num   = n;
        in_key   = k;
        clear    = clr;
        step();
        if (clr) begin
            exp_mask = '0;
            exp_ovw  = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            // Disturb the inputs while busy; none of it may be honoured.
            in_valid = keep_valid;
            if (keep_valid) begin
                in_num = 4'($urandom);
                in_key = 4'($urandom);
            end
            clear = busy_clr;
            if (c == 3) begin
                if (exp_mask[n]) exp_ovw = 1'b1;
                exp_mask[n] = 1'b1;
                exp_count   = (exp_count + 1) % 256;
            end
            check("busy.en",       32'(en),       32'(c < 2));
            check("busy.we",       32'(we),       32'(c == 2));
            check("busy.done",     32'(done),     32'(c == 3));
            check("busy.in_ready", 32'(in_ready), 32'd0);
            check("busy.num",      32'(num),      32'(n));
            check("busy.key",      32'(key),      32'(k));
            check_status("busy");
            step();
        end
        clear    = 1'b0;
        in_valid = keep_valid;
        check("after.in_ready", 32'(in_ready), 32'd1);
        check("after.done",     32'(done),     32'd0);
        check("after.we",       32'(we),       32'd0);
    endtask

    // Idle cycles with no request; optional clear on the first one.
    task automatic idle(input int cycles, input logic clr);
        for (int c = 0; c < cycles; c++) begin
            in_valid = 1'b0;
            clear    = (c == 0) ? clr : 1'b0;
            step();
            if (c == 0 && clr) begin
                exp_mask = '0;
                exp_ovw  = 1'b0;
            end
            check("idle.in_ready", 32'(in_ready), 32'd1);
            check("idle.en",       32'(en),       32'd0);
            check("idle.we",       32'(we),       32'd0);
            check("idle.done",     32'(done),     32'd0);
            check_status("idle");
        end
        clear = 1'b0;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        step();
        reset = 1'b0;
        model_reset();
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.en",       32'(en),       32'd0);
        check("reset.we",       32'(we),       32'd0);
        check("reset.done",     32'(done),     32'd0);
        check("reset.num",      32'(num),      32'd0);
        check("reset.key",      32'(key),      32'd0);
        check_status("reset");
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_num   = '0;
        in_key   = '0;
        clear    = 1'b0;
        model_reset();
        #1;
        apply_reset();

        // Single request num=3, key=5.
        run_req(4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
        check("single.mask", 32'(wr_mask), 32'h0008);

        // Held in_valid: num 1,2,4 accepted back to back.
        apply_reset();
        run_req(4'd1, 4'hA, 1'b0, 1'b0, 1'b1);
        run_req(4'd2, 4'hB, 1'b0, 1'b0, 1'b1);
        run_req(4'd4, 4'hC, 1'b0, 1'b0, 1'b0);
        check("held.mask",  32'(wr_mask),  32'h0016);
        check("held.count", 32'(wr_count), 32'd3);

        // Two writes to entry 7, then clear in IDLE.
        apply_reset();
        run_req(4'd7, 4'd1, 1'b0, 1'b0, 1'b0);
        run_req(4'd7, 4'd2, 1'b0, 1'b0, 1'b0);
        check("ovw.flag", 32'(overwrite), 32'd1);
        idle(2, 1'b1);
        check("ovw.cleared_mask",  32'(wr_mask),  32'd0);
        check("ovw.cleared_count", 32'(wr_count), 32'd2);

        // Reset during ROT of num=9: no we/done, all back to reset values.
        in_valid = 1'b1;
        in_num   = 4'd9;
        in_key   = 4'd6;
        step();
        in_valid = 1'b0;
        check("abort.load_en", 32'(en), 32'd1);
        step();
        check("abort.rot_en", 32'(en), 32'd1);
        check("abort.rot_we", 32'(we), 32'd0);
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            step();
            check("abort.we",   32'(we),   32'd0);
            check("abort.done", 32'(done), 32'd0);
        end

        // clear held through the busy phase (LOAD..DONE) is ignored.
        run_req(4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
        run_req(4'd2, 4'd3, 1'b0, 1'b1, 1'b0);
        check("busyclr.mask", 32'(wr_mask),   32'h0004);
        check("busyclr.ovw",  32'(overwrite), 32'd1);

        // clear together with accept of num=0, mask 00F0 beforehand.
        apply_reset();
        for (int i = 4; i < 8; i++) run_req(4'(i), 4'($urandom), 1'b0, 1'b0, 1'b0);
        check("clracc.before", 32'(wr_mask), 32'h00F0);
        run_req(4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        check("clracc.after", 32'(wr_mask), 32'h0001);

        // 256 writes: count wraps to 0, mask saturates.
        apply_reset();
        for (int i = 0; i < 256; i++) run_req(4'(i % 16), 4'($urandom), 1'b0, 1'b0, 1'b0);
        check("wrap.count", 32'(wr_count), 32'd0);
        check("wrap.mask",  32'(wr_mask),  32'hFFFF);

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(3) + 1, 1'($urandom_range(1)));
            run_req(4'($urandom), 4'($urandom), ($urandom_range(3) == 0),
                    1'($urandom_range(1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Control stage directly upstream of the 4-bit encrypt datapath (input register, rotator, multiplier, address decoder, 16-entry memory). It accepts (num, key) requests over a valid/ready handshake and holds the operands stable. It sequences the datapath's enable and write-enable strobes through the two-register pipeline, so each product is written exactly once to the entry addressed by num. It also keeps occupancy and overwrite status for the 16 memory entries.

## Interface
- No parameters; all widths are fixed by the datapath (4-bit operands, 16 entries).
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high; one clock edge with reset=1 fully resets the block
- in_valid  input  1  request present
- in_num  input  4  operand; also the memory entry index
- in_key  input  4  multiplier key
- clear  input  1  clear the occupancy mask; honoured only in IDLE
- in_ready  output  1  block can accept a request (combinational: state==IDLE)
- num  output  4  registered operand driven to the datapath
- key  output  4  registered key driven to the datapath
- en  output  1  datapath register enable
- we  output  1  datapath memory write-enable, one-cycle pulse
- done  output  1  one-cycle pulse; request complete
- wr_mask  output  16  bit i set when entry i has been written since reset/clear
- wr_count  output  8  writes since reset, wraps 255->0
- overwrite  output  1  sticky; set when a write targets an already-set wr_mask bit

## Operation
- States: IDLE, LOAD, ROT, WRITE, DONE. Encoding is free.
- IDLE: in_ready=1, en=0, we=0. When in_valid&&in_ready at a rising edge, latch num<=in_num and key<=in_key, then go to LOAD.
- LOAD: en=1, so the datapath input register captures num. Go to ROT.
- ROT: en=1, so the rotator captures the registered num. Go to WRITE.
- WRITE: en=0, we=1. The memory stores rot(num)*key at the entry decoded from num. At the closing edge:
  - wr_mask[num]<=1.
  - wr_count<=wr_count+1, wrapping modulo 256.
  - If wr_mask[num] was already 1, overwrite<=1.
  - Go to DONE.
- DONE: done=1, we=0. Go to IDLE.
- num and key are held constant from the accept edge until the next accept; they never change outside IDLE.
- en, we, done and in_ready are decoded from state only and are glitch-free registered-state decodes.
- clear in IDLE: wr_mask<=0 and overwrite<=0. wr_count is unaffected. clear in any other state is ignored.
- clear and accept on the same edge: the mask clears, the request is accepted, and its later WRITE sets only its own bit.
- in_valid outside IDLE is ignored. The requester must hold in_valid and its data until in_ready=1.

## Timing
- Reset: state=IDLE, num=0, key=0, en=0, we=0, done=0, wr_mask=0, wr_count=0, overwrite=0. in_ready=1 in the first cycle after reset deasserts.
- Accept at edge N: en high during cycles N..N+1 (LOAD, ROT), we high during cycle N+2, done high during cycle N+3, in_ready high again from cycle N+4.
- Throughput: one request per 4 cycles. Back-to-back requests are accepted at edges N, N+4, N+8, and so on.
- wr_mask, wr_count and overwrite update on the edge ending WRITE, and are visible in the DONE cycle.
- Reset mid-operation, in any state: return to IDLE on that edge.
  - An aborted request issues no we pulse if reset occurs before the WRITE cycle.
  - All status is cleared.
  - No done pulse is issued for the aborted request.
- Wrap: after 256 writes wr_count=0. wr_mask saturates at 16'hFFFF.

## Test plan
- Single request in_num=3, in_key=5 accepted at edge N:
  - en=1 in cycles N, N+1; we=1 only in cycle N+2; done=1 only in cycle N+3.
  - wr_mask=16'h0008, wr_count=1, overwrite=0.
- in_valid held high with num=1,2,4 presented in turn:
  - Accepts occur 4 cycles apart and in_ready=0 between them.
  - wr_mask=16'h0016, wr_count=3.
  - num/key never change during LOAD..DONE.
- Two requests, both num=7:
  - Second DONE shows overwrite=1, wr_mask=16'h0080, wr_count=2.
  - clear in the next IDLE gives wr_mask=0, overwrite=0, wr_count=2.
- Reset asserted during ROT of a request num=9:
  - we never pulses, done never pulses.
  - Next cycle shows IDLE with all outputs at reset values.
- clear asserted during LOAD: ignored.
- clear together with accept of num=0 in IDLE, with wr_mask=16'h00F0 beforehand: final wr_mask=16'h0001.
- 256 requests: wr_count returns to 0 and wr_mask saturates at 16'hFFFF.
